// File: rtl/jtoutrun_obj_scan.sv
// Per-line object table scanner: finds entries covering the rendered line and hands them to the draw engine.
// Define JTOUTRUN_OBJ_WB_EN to write the advanced row address (w5 + w3) back into the table.
module jtoutrun_obj_scan (
   input  logic        clk,
   input  logic        rst,
   input  logic        hstart,
   input  logic [8:0]  vrender,
   output logic [9:0]  tbl_addr,
   input  logic [15:0] tbl_dout,
   output logic        tbl_we,
   output logic [15:0] tbl_din,
   output logic        dr_req,
   input  logic        dr_ack,
   output logic [15:0] dr_xpos,
   output logic [15:0] dr_base,
   output logic [15:0] dr_row,
   output logic [15:0] dr_attr0,
   output logic [15:0] dr_attr1,
   output logic        scan_done
);

   typedef enum logic [2:0] {IDLE, RD0, CHK, RDX, REQ, WB, NEXT} state_t;

   state_t     state, state_nx;
   logic [6:0] entry;
   logic [2:0] word, step;
   logic [8:0] vline, top, bot;
   logic       hide, last, visible;
`ifdef JTOUTRUN_OBJ_WB_EN
   logic [15:0] pitch;
`endif

   // bot is exclusive, so top==bot can never match
   assign visible   = !hide && (vline >= top) && (vline < bot);
   assign tbl_addr  = {entry, word};
   assign dr_req    = (state == REQ);
   assign scan_done = (state == IDLE);

`ifdef JTOUTRUN_OBJ_WB_EN
   assign tbl_we  = (state == WB);
   assign tbl_din = tbl_we ? dr_row + pitch : '0;
`else
   assign tbl_we  = 1'b0;
   assign tbl_din = '0;
`endif

   always_ff @(posedge clk, posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (hstart) begin
         state_nx = RD0;
      end else begin
         case (state)
            IDLE: state_nx = IDLE;
            RD0:  if (step == 3'd2) state_nx = CHK;
            CHK: begin
               if (last)          state_nx = IDLE;
               else if (!visible) state_nx = NEXT;
               else               state_nx = RDX;
            end
            RDX:  if (step == 3'd6) state_nx = REQ;
`ifdef JTOUTRUN_OBJ_WB_EN
            REQ:  if (dr_ack) state_nx = WB;
`else
            REQ:  if (dr_ack) state_nx = NEXT;
`endif
            WB:   state_nx = NEXT;
            NEXT: state_nx = (entry == 7'd127) ? IDLE : RD0;
            default: state_nx = IDLE;
         endcase
      end
   end

   // step counts cycles within RD0/RDX; data for the address of step n arrives at step n+1
   always_ff @(posedge clk, posedge rst) begin
      if (rst) begin
         entry    <= '0;
         word     <= '0;
         step     <= '0;
         vline    <= '0;
         top      <= '0;
         bot      <= '0;
         hide     <= 1'b0;
         last     <= 1'b0;
         dr_xpos  <= '0;
         dr_base  <= '0;
         dr_row   <= '0;
         dr_attr0 <= '0;
         dr_attr1 <= '0;
`ifdef JTOUTRUN_OBJ_WB_EN
         pitch    <= '0;
`endif
      end else if (hstart) begin
         vline <= vrender;
         entry <= '0;
         word  <= '0;
         step  <= '0;
      end else begin
         case (state)
            RD0: begin
               step <= step + 3'd1;
               word <= 3'd1;
               if (step == 3'd1) begin
                  last <= tbl_dout[15];
                  hide <= tbl_dout[14];
                  top  <= tbl_dout[8:0];
               end
               if (step == 3'd2) bot <= tbl_dout[8:0];
            end
            CHK: begin
               step <= '0;
               word <= 3'd2;
            end
            RDX: begin
               step <= step + 3'd1;
               if (word != 3'd7) word <= word + 3'd1;
               case (step)
                  3'd1: dr_xpos  <= tbl_dout;
`ifdef JTOUTRUN_OBJ_WB_EN
                  3'd2: pitch    <= tbl_dout;
`endif
                  3'd3: dr_base  <= tbl_dout;
                  3'd4: dr_row   <= tbl_dout;
                  3'd5: dr_attr0 <= tbl_dout;
                  3'd6: dr_attr1 <= tbl_dout;
                  default: ;
               endcase
            end
            REQ: if (dr_ack) word <= 3'd5;
            NEXT: begin
               entry <= entry + 7'd1;
               word  <= '0;
               step  <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jtoutrun_obj_scan.sv
// Scoreboard bench for jtoutrun_obj_scan: table model predicts draw requests and write-backs per scan.
module tb_jtoutrun_obj_scan;

   logic        clk = 1'b0;
   logic        rst, hstart, dr_ack, tbl_we, dr_req, scan_done;
   logic [8:0]  vrender;
   logic [9:0]  tbl_addr;
   logic [15:0] tbl_dout, tbl_din, dr_xpos, dr_base, dr_row, dr_attr0, dr_attr1;

   typedef struct packed {logic [15:0] xpos, base, row, attr0, attr1;} req_t;
   typedef struct packed {logic [9:0] addr; logic [15:0] data; logic [15:0] old;} wr_t;

   logic [15:0] mem     [0:1023];
   logic [15:0] ref_mem [0:1023];
   logic        load;
   req_t        rq[$];
   wr_t         wq[$];
   int          checks = 0, errors = 0, ack_mode = 1;

   jtoutrun_obj_scan dut (
      .clk(clk), .rst(rst), .hstart(hstart), .vrender(vrender),
      .tbl_addr(tbl_addr), .tbl_dout(tbl_dout), .tbl_we(tbl_we), .tbl_din(tbl_din),
      .dr_req(dr_req), .dr_ack(dr_ack), .dr_xpos(dr_xpos), .dr_base(dr_base),
      .dr_row(dr_row), .dr_attr0(dr_attr0), .dr_attr1(dr_attr1), .scan_done(scan_done)
   );

   always #5 clk = ~clk;

   // synchronous table RAM, one cycle read latency
   always @(posedge clk) begin
      if (load) for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
      else if (tbl_we) mem[tbl_addr] <= tbl_din;
      tbl_dout <= mem[tbl_addr];
   end

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference: walk the table by its rules, predicting requests and write-backs in order
   task automatic build_expect(input logic [8:0] v);
      logic [15:0] w [8];
      for (int e = 0; e < 128; e++) begin
         for (int k = 0; k < 8; k++) w[k] = ref_mem[e*8+k];
         if (w[0][15]) break;
         if (!w[0][14] && v >= w[0][8:0] && v < w[1][8:0]) begin
            rq.push_back({w[2], w[4], w[5], w[6], w[7]});
`ifdef JTOUTRUN_OBJ_WB_EN
            wq.push_back('{addr: 10'(e*8+5), data: w[5] + w[3], old: w[5]});
            ref_mem[e*8+5] = w[5] + w[3];
`endif
         end
      end
   endtask

   // drop pending predictions; undo model writes that never happened
   task automatic flush();
      wr_t w;
      while (wq.size() > 0) begin
         w = wq.pop_back();
         ref_mem[w.addr] = w.old;
      end
      rq.delete();
   endtask

   task automatic load_table();
      @(posedge clk); #1 load = 1'b1;
      @(posedge clk); #1 load = 1'b0;
   endtask

   task automatic directed_table();
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      ref_mem[0] = 16'h0010; ref_mem[1] = 16'h0020; ref_mem[2] = 16'h0A0A; ref_mem[3] = 16'h0100;
      ref_mem[4] = 16'h0B0B; ref_mem[5] = 16'h1000; ref_mem[6] = 16'h0C0C; ref_mem[7] = 16'h0D0D;
      ref_mem[8] = 16'h8000;
      load_table();
   endtask

   task automatic fill_random();
      int end_at;
      end_at = $urandom_range(1, 160);
      for (int e = 0; e < 128; e++) begin
         logic [8:0] top, bot;
         logic       hide;
         top  = 9'($urandom_range(0, 400));
         bot  = top + 9'($urandom_range(0, 120));
         hide = ($urandom_range(0, 7) == 0);
         ref_mem[e*8]   = {(e == end_at), hide, 5'($urandom), top};
         ref_mem[e*8+1] = {7'($urandom), bot};
         for (int k = 2; k < 8; k++) ref_mem[e*8+k] = 16'($urandom);
      end
      load_table();
   endtask

   task automatic launch(input logic [8:0] v);
      @(posedge clk); #1;
      flush();
      build_expect(v);
      vrender = v;
      hstart  = 1'b1;
      @(posedge clk); #1;
      hstart  = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!scan_done && n < 10000) begin @(negedge clk); n++; end
      check("scan_done", 80'(scan_done), 80'd1);
      check("req_left", 80'(rq.size()), 80'd0);
      check("wr_left", 80'(wq.size()), 80'd0);
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (!dr_req && n < 2000) begin @(negedge clk); n++; end
      check("req_seen", 80'(dr_req), 80'd1);
   endtask

   task automatic run_scan(input logic [8:0] v);
      launch(v);
      wait_done();
   endtask

   // responder and monitor: drives dr_ack, pops the scoreboard on handshakes and writes
   initial begin
      logic acked_prev;
      acked_prev = 1'b0;
      dr_ack = 1'b0;
      forever begin
         @(negedge clk);
         dr_ack = !hstart && ((ack_mode == 2) || (ack_mode == 1 && $urandom_range(0, 2) == 0));
         if (rst || hstart) begin
            acked_prev = 1'b0;
         end else begin
            if (acked_prev) check("req_drop", 80'(dr_req), 80'd0);
            acked_prev = 1'b0;
            if (dr_req) begin
               if (rq.size() == 0) check("req_pending", 80'(dr_req), 80'd0);
               else begin
                  check("req_fields", {dr_xpos, dr_base, dr_row, dr_attr0, dr_attr1}, rq[0]);
                  if (dr_ack) begin
                     void'(rq.pop_front());
                     acked_prev = 1'b1;
                  end
               end
            end
            if (tbl_we) begin
               if (wq.size() == 0) check("wr_pending", 80'(tbl_we), 80'd0);
               else begin
                  check("wr_addr_data", 80'({tbl_addr, tbl_din}), 80'({wq[0].addr, wq[0].data}));
                  void'(wq.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] exp5;
      rst = 1'b1; hstart = 1'b0; vrender = '0; load = 1'b0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_addr", 80'(tbl_addr), 80'd0);
      check("rst_we", 80'(tbl_we), 80'd0);
      check("rst_din", 80'(tbl_din), 80'd0);
      check("rst_req", 80'(dr_req), 80'd0);
      check("rst_data", {dr_xpos, dr_base, dr_row, dr_attr0, dr_attr1}, 80'd0);
      check("rst_done", 80'(scan_done), 80'd1);
      rst = 1'b0;

      // single visible entry, then list end
      directed_table();
      run_scan(9'h018);
`ifdef JTOUTRUN_OBJ_WB_EN
      exp5 = 16'h1100;
`else
      exp5 = 16'h1000;
`endif
      check("wb_word5", 80'(mem[5]), 80'(exp5));

      // range boundaries: bottom exclusive, below top, top inclusive, top==bottom
      directed_table();
      run_scan(9'h020);
      run_scan(9'h00F);
      run_scan(9'h010);
      run_scan(9'h01F);
      ref_mem[1] = 16'h0010;
      load_table();
      run_scan(9'h010);

      // hidden entry
      directed_table();
      ref_mem[0] = 16'h4010;
      load_table();
      run_scan(9'h018);

      // request held 50 cycles without ack, then accepted
      directed_table();
      ack_mode = 0;
      launch(9'h018);
      wait_req();
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         check("hold_req", 80'(dr_req), 80'd1);
      end
      ack_mode = 2;
      @(posedge clk); #1;
      check("ack_drop", 80'(dr_req), 80'd0);
      ack_mode = 1;
      wait_done();

      // abort while requesting
      directed_table();
      ack_mode = 0;
      launch(9'h018);
      wait_req();
      launch(9'h018);
      check("abort_req", 80'(dr_req), 80'd0);
      check("abort_we", 80'(tbl_we), 80'd0);
      check("abort_addr", 80'(tbl_addr), 80'd0);
      ack_mode = 1;
      wait_done();

      // 16-bit wrap of the write-back sum
      directed_table();
      ref_mem[3] = 16'h0020; ref_mem[5] = 16'hFFF0;
      load_table();
      run_scan(9'h018);
`ifdef JTOUTRUN_OBJ_WB_EN
      exp5 = 16'h0010;
`else
      exp5 = 16'hFFF0;
`endif
      check("wb_wrap", 80'(mem[5]), 80'(exp5));

      // reset in the middle of a request
      directed_table();
      ack_mode = 0;
      launch(9'h018);
      wait_req();
      @(posedge clk); #1;
      rst = 1'b1;
      flush();
      #1;
      check("mrst_req", 80'(dr_req), 80'd0);
      check("mrst_we", 80'(tbl_we), 80'd0);
      check("mrst_done", 80'(scan_done), 80'd1);
      check("mrst_addr", 80'(tbl_addr), 80'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      ack_mode = 1;
      run_scan(9'h018);

      // random tables, each reused once so write-backs feed the next scan
      for (int i = 0; i < 12; i++) begin
         if (i % 2 == 0) fill_random();
         run_scan(9'($urandom_range(0, 511)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jtoutrun_obj_scan.md
JTOUTRUN_OBJ_SCAN -- requirements
Module: jtoutrun_obj_scan

Interface
REQ-001 SHALL have clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have hstart  input  1  one-cycle pulse starting the scan of a new line.
REQ-004 SHALL have vrender  input  9  line being prepared; sampled on hstart.
REQ-005 SHALL have tbl_addr  output  10  object table word address {entry[6:0], word[2:0]}.
REQ-006 SHALL have tbl_dout  input  16  table read data, valid one cycle after tbl_addr.
REQ-007 SHALL have tbl_we  output  1  table write strobe, both bytes.
REQ-008 SHALL have tbl_din  output  16  table write data.
REQ-009 SHALL have dr_req  output  1  draw request, held until accepted.
REQ-010 SHALL have dr_ack  input  1  draw engine accepts the request in a cycle where dr_req=1 and dr_ack=1.
REQ-011 SHALL have dr_xpos, dr_base, dr_row, dr_attr0, dr_attr1  output  16 each  copies of words 2, 4, 5 (pre-update), 6, 7.
REQ-012 SHALL have scan_done  output  1  high while idle after list end, entry 127, or reset.

Function
REQ-013 Entry layout SHALL be: w0[15]=end, w0[14]=hide, w0[8:0]=top; w1[8:0]=bottom (exclusive); w3=signed pitch; w5=running row address.
REQ-014 FSM states SHALL be IDLE, RD0, CHK, RDX, REQ, WB, NEXT.
REQ-015 IDLE: on hstart, latch vrender, set entry=0, clear scan_done, go RD0.
REQ-016 RD0: drive word 0, then word 1; one cycle of read latency each; go CHK once both are captured.
REQ-017 CHK: w0.end=1 -> IDLE with scan_done=1; hide=1 or vrender outside [top,bottom) -> NEXT; otherwise -> RDX.
REQ-018 Range compare SHALL be unsigned 9-bit; top==bottom means never visible; vrender==bottom is not visible.
REQ-019 RDX: read words 2..7 in order, one per cycle, pipelined, and latch them into the output registers; then go REQ.
REQ-020 REQ: hold dr_req=1 with stable outputs until dr_ack; dr_req SHALL drop the cycle after ack; go WB.
REQ-021 WB: tbl_we=1 for one cycle at word 5 with tbl_din = w5 + w3, a 16-bit wrap-around sum; go NEXT.
REQ-022 NEXT: entry 127 -> IDLE with scan_done=1; otherwise entry+1 -> RD0.
REQ-023 An hstart pulse in any non-IDLE state SHALL abort the scan: dr_req=0 and tbl_we=0 next cycle, the pending write-back is discarded, vrender is relatched, and the scan restarts at entry 0 in RD0.
REQ-024 dr_ack while dr_req=0 SHALL be ignored.
REQ-025 tbl_we SHALL be asserted only in WB.

Reset
REQ-026 Under rst the block SHALL be in IDLE with: entry=0, tbl_addr=0, tbl_we=0, tbl_din=0, dr_req=0, all dr_* data outputs=0, scan_done=1.
REQ-027 rst asserted mid-scan SHALL take effect immediately with no write issued; the first hstart after release starts a clean scan.

Configuration
REQ-028 Macro JTOUTRUN_OBJ_WB_EN: defined -> WB behaves as REQ-021; undefined -> the WB state is skipped (REQ goes directly to NEXT), tbl_we is constant 0, tbl_din is constant 0, and table contents are never modified.

Verification
REQ-029 Entry 0 {w0=0x0010, w1=0x0020, w3=0x0100, w5=0x1000}, entry 1 w0=0x8000; hstart with vrender=0x18 -> exactly one dr_req with dr_row=0x1000; tbl_we writes 0x1100 to address 0x005; then scan_done=1.
REQ-030 Same table with vrender=0x20 and 0x0F -> no dr_req, no tbl_we, scan_done=1 after entry 1.
REQ-031 Visible entry with hide=1 (w0=0x4010) and vrender=0x18 -> skipped, no request.
REQ-032 Hold dr_ack=0 for 50 cycles -> dr_req and dr_* stay stable; ack on cycle 51 -> dr_req=0 next cycle.
REQ-033 hstart while in REQ -> dr_req=0 next cycle, no write to word 5, scan restarts at tbl_addr=0x000.
REQ-034 w5=0xFFF0 and w3=0x0020 -> write-back 0x0010; with JTOUTRUN_OBJ_WB_EN undefined -> tbl_we never asserts.
